pid_controller_mc: RTL and testbench

Multi-channel, time-multiplexed fixed-point PID controller for the motor control path. It serves CHANNELS motors with one shared multiplier and a sequential per-channel datapath. It adds an integral term with anti-windup, a deadband, per-channel modes and a start/busy/done handshake. Each channel has its own bank of gains, limits and state, written through a configuration port and consumed once per `update_controller` request.

---
 rtl/pid_controller_mc_if.sv | 39 +++
 rtl/pid_controller_mc.sv | 252 +++++++++++++++++++++++++
 tb/tb_pid_controller_mc.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pid_controller_mc_if.sv
// Request/status handshake and configuration port
// of the multi-channel PID controller.
interface pid_controller_mc_if #(
  parameter int DATA_W = 32
);
  logic              update_controller;
  logic              busy;
  logic              done;
  logic              overrun;
  logic              cfg_write;
  logic [5:0]        cfg_channel;
  logic [3:0]        cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_error;

  modport master (
    output update_controller,
    output cfg_write,
    output cfg_channel,
    output cfg_addr,
    output cfg_data,
    input  busy,
    input  done,
    input  overrun,
    input  cfg_error
  );

  modport slave (
    input  update_controller,
    input  cfg_write,
    input  cfg_channel,
    input  cfg_addr,
    input  cfg_data,
    output busy,
    output done,
    output overrun,
    output cfg_error
  );
endinterface

// File: rtl/pid_controller_mc.sv
// Time-multiplexed fixed-point PID controller, one shared
// multiplier, six cycles per channel.
module pid_controller_mc #(
  parameter int CHANNELS  = 8,
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  pid_controller_mc_if.slave         ctl,
  input  logic [CHANNELS*DATA_W-1:0] state,
  input  logic [CHANNELS*DATA_W-1:0] setpoint,
  output logic [CHANNELS*DATA_W-1:0] result
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

  typedef logic signed [DATA_W-1:0]   word_t;
  typedef logic signed [DATA_W:0]     wide_t;
  typedef logic signed [DATA_W+1:0]   sum_t;
  typedef logic signed [2*DATA_W-1:0] prod_t;

  localparam word_t WMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam word_t WMIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, LOAD, MUL_P, MUL_I, MUL_D, SUM, WRITE, DONE
  } fsm_t;

  function automatic wide_t ext1(input word_t x);
    return {x[DATA_W-1], x};
  endfunction

  function automatic sum_t ext2(input word_t x);
    return {{2{x[DATA_W-1]}}, x};
  endfunction

  function automatic word_t sat1(input wide_t x);
    if (x[DATA_W] != x[DATA_W-1])
      return x[DATA_W] ? WMIN : WMAX;
    return x[DATA_W-1:0];
  endfunction

  function automatic word_t satp(input prod_t x);
    logic [DATA_W:0] hi;
    hi = x[2*DATA_W-1:DATA_W-1];
    if ((&hi) || (~|hi))
      return x[DATA_W-1:0];
    return x[2*DATA_W-1] ? WMIN : WMAX;
  endfunction

  // Upper bound wins when the limits are inverted.
  function automatic word_t clamp(
    input sum_t  x,
    input word_t lo,
    input word_t hi
  );
    sum_t y;
    y = x;
    if (y < ext2(lo)) y = ext2(lo);
    if (y > ext2(hi)) y = ext2(hi);
    return y[DATA_W-1:0];
  endfunction

  word_t      kp    [CHANNELS];
  word_t      ki    [CHANNELS];
  word_t      kd    [CHANNELS];
  word_t      opmax [CHANNELS];
  word_t      onmax [CHANNELS];
  word_t      ipmax [CHANNELS];
  word_t      inmax [CHANNELS];
  word_t      dband [CHANNELS];
  logic [1:0] mode  [CHANNELS];
  word_t      integ [CHANNELS];
  word_t      eprev [CHANNELS];
  word_t      res   [CHANNELS];

  fsm_t          fsm;
  logic [CW-1:0] ch;
  word_t         err_q;
  word_t         sp_q;
  word_t         p_q;
  word_t         d_q;
  word_t         sum_q;
  logic          dead_q;
  logic          busy_q;
  logic          done_q;
  logic          overrun_q;
  logic          cfg_error_q;

  word_t st_c;
  word_t sp_c;
  word_t err_c;
  wide_t abs_c;
  logic  dead_c;
  word_t diff_c;
  word_t mul_a;
  word_t mul_b;
  prod_t prod;
  word_t mul_c;
  logic  p_ok;
  word_t integ_c;
  logic  cfg_ok;

  always_comb begin
    st_c   = state[int'(ch)*DATA_W +: DATA_W];
    sp_c   = setpoint[int'(ch)*DATA_W +: DATA_W];
    err_c  = sat1(ext1(sp_c) - ext1(st_c));
    abs_c  = err_c[DATA_W-1] ? -ext1(err_c) : ext1(err_c);
    dead_c = abs_c <= ext1(dband[ch]);
    diff_c = sat1(ext1(err_q) - ext1(eprev[ch]));
    mul_a  = kp[ch];
    mul_b  = err_q;
    unique case (fsm)
      MUL_I: mul_a = ki[ch];
      MUL_D: begin
        mul_a = kd[ch];
        mul_b = diff_c;
      end
      default: ;
    endcase
    prod = $signed({{DATA_W{mul_a[DATA_W-1]}}, mul_a})
         * $signed({{DATA_W{mul_b[DATA_W-1]}}, mul_b});
    mul_c = satp(prod >>> FRAC_BITS);
    p_ok  = (p_q >= onmax[ch]) && (p_q <= opmax[ch]);
    integ_c = clamp(
      ext2(sat1(ext1(integ[ch]) + ext1(mul_c))),
      inmax[ch], ipmax[ch]);
    cfg_ok = ({1'b0, ctl.cfg_channel} < 7'(CHANNELS))
          && (ctl.cfg_addr <= 4'd8);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm         <= IDLE;
      ch          <= '0;
      err_q       <= '0;
      sp_q        <= '0;
      p_q         <= '0;
      d_q         <= '0;
      sum_q       <= '0;
      dead_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      cfg_error_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        kp[i]    <= '0;
        ki[i]    <= '0;
        kd[i]    <= '0;
        opmax[i] <= '0;
        onmax[i] <= '0;
        ipmax[i] <= '0;
        inmax[i] <= '0;
        dband[i] <= '0;
        mode[i]  <= 2'd2;
        integ[i] <= '0;
        eprev[i] <= '0;
        res[i]   <= '0;
      end
    end else begin
      done_q      <= 1'b0;
      overrun_q   <= ctl.update_controller && busy_q;
      cfg_error_q <= ctl.cfg_write && (busy_q || !cfg_ok);

      if (ctl.cfg_write && !busy_q && cfg_ok) begin
        case (ctl.cfg_addr)
          4'd0: kp[ctl.cfg_channel[CW-1:0]]    <= ctl.cfg_data;
          4'd1: ki[ctl.cfg_channel[CW-1:0]]    <= ctl.cfg_data;
          4'd2: kd[ctl.cfg_channel[CW-1:0]]    <= ctl.cfg_data;
          4'd3: opmax[ctl.cfg_channel[CW-1:0]] <= ctl.cfg_data;
          4'd4: onmax[ctl.cfg_channel[CW-1:0]] <= ctl.cfg_data;
          4'd5: ipmax[ctl.cfg_channel[CW-1:0]] <= ctl.cfg_data;
          4'd6: inmax[ctl.cfg_channel[CW-1:0]] <= ctl.cfg_data;
          4'd7: dband[ctl.cfg_channel[CW-1:0]] <= ctl.cfg_data;
          4'd8: mode[ctl.cfg_channel[CW-1:0]]  <= ctl.cfg_data[1:0];
          default: ;
        endcase
      end

      unique case (fsm)
        IDLE, DONE: begin
          if (ctl.update_controller) begin
            fsm    <= LOAD;
            ch     <= '0;
            busy_q <= 1'b1;
          end else begin
            fsm <= IDLE;
          end
        end
        LOAD: begin
          err_q  <= err_c;
          sp_q   <= sp_c;
          dead_q <= dead_c;
          fsm    <= MUL_P;
        end
        MUL_P: begin
          p_q <= mul_c;
          fsm <= MUL_I;
        end
        MUL_I: begin
          if (mode[ch] == 2'd0 && !dead_q && p_ok)
            integ[ch] <= integ_c;
          fsm <= MUL_D;
        end
        MUL_D: begin
          d_q <= mul_c;
          if (mode[ch] == 2'd0)
            eprev[ch] <= err_q;
          fsm <= SUM;
        end
        SUM: begin
          sum_q <= clamp(
            ext2(p_q) + ext2(integ[ch]) + ext2(d_q),
            onmax[ch], opmax[ch]);
          fsm <= WRITE;
        end
        WRITE: begin
          unique case (mode[ch])
            2'd0: res[ch] <= dead_q ? '0 : sum_q;
            2'd1: res[ch] <= clamp(ext2(sp_q),
                                   onmax[ch], opmax[ch]);
            default: begin
              res[ch]   <= '0;
              integ[ch] <= '0;
              eprev[ch] <= '0;
            end
          endcase
          if (ch == LAST) begin
            fsm    <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            ch  <= ch + 1'b1;
            fsm <= LOAD;
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_res
    assign result[g*DATA_W +: DATA_W] = res[g];
  end

  assign ctl.busy      = busy_q;
  assign ctl.done      = done_q;
  assign ctl.overrun   = overrun_q;
  assign ctl.cfg_error = cfg_error_q;

endmodule

// File: tb/tb_pid_controller_mc.sv
// Directed testbench for pid_controller_mc with four channels
// and hand-computed expectations.
module tb_pid_controller_mc;
  localparam int N = 4;
  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic [N*W-1:0] state;
  logic [N*W-1:0] setpoint;
  logic [N*W-1:0] result;
  int checks;
  int failures;

  pid_controller_mc_if #(.DATA_W(W)) bus();

  pid_controller_mc #(
    .CHANNELS(N), .DATA_W(W), .FRAC_BITS(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ctl(bus),
    .state(state),
    .setpoint(setpoint),
    .result(result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic signed [W-1:0] res(input int c);
    return result[c*W +: W];
  endfunction

  task automatic set_io(input int c, input int sp, input int st);
    setpoint[c*W +: W] = sp;
    state[c*W +: W]    = st;
  endtask

  task automatic cfg(input int c, input int a, input int d);
    bus.cfg_write   = 1'b1;
    bus.cfg_channel = 6'(c);
    bus.cfg_addr    = 4'(a);
    bus.cfg_data    = d;
    @(negedge clock);
    bus.cfg_write = 1'b0;
  endtask

  task automatic cfg_pid(input int c, input int kp, input int ki,
                         input int kd, input int opx, input int onx,
                         input int ipx, input int inx, input int db,
                         input int md);
    cfg(c, 0, kp);  cfg(c, 1, ki);  cfg(c, 2, kd);
    cfg(c, 3, opx); cfg(c, 4, onx); cfg(c, 5, ipx);
    cfg(c, 6, inx); cfg(c, 7, db);  cfg(c, 8, md);
  endtask

  task automatic run_pass(output int lat, output int bcnt);
    bcnt = 0;
    bus.update_controller = 1'b1;
    @(negedge clock);
    bus.update_controller = 1'b0;
    lat = 1;
    while (!bus.done && lat < 200) begin
      if (bus.busy) bcnt++;
      @(negedge clock);
      lat++;
    end
    if (bus.busy) bcnt++;
  endtask

  task automatic test_reset;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_status busy=%b done=%b exp 0 0",
               bus.busy, bus.done);
    end
    checks++;
    if (bus.overrun !== 1'b0 || bus.cfg_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses overrun=%b cfg_error=%b exp 0 0",
               bus.overrun, bus.cfg_error);
    end
    checks++;
    if (result !== '0) begin
      failures++;
      $display("FAIL reset_result got=%h exp 0", result);
    end
  endtask

  task automatic test_basic;
    int lat, b;
    cfg_pid(0, 32'h20000, 0, 0, 10000, -10000, 10000, -10000, 0, 0);
    set_io(0, 1000, 400);
    run_pass(lat, b);
    checks++;
    if (res(0) !== 32'sd1200) begin
      failures++;
      $display("FAIL basic_r0 got=%0d exp=1200", res(0));
    end
    checks++;
    if (lat != 25) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=25", lat);
    end
    checks++;
    if (b != 24) begin
      failures++;
      $display("FAIL basic_busy_cycles got=%0d exp=24", b);
    end
    checks++;
    if (res(1) !== 32'sd0) begin
      failures++;
      $display("FAIL basic_disabled_r1 got=%0d exp=0", res(1));
    end
  endtask

  task automatic test_derivative;
    int lat, b;
    int sp [2] = '{100, 150};
    int ex [2] = '{100, 50};
    cfg_pid(2, 0, 0, 32'h10000, 10000, -10000, 10000, -10000, 0, 0);
    for (int i = 0; i < 2; i++) begin
      set_io(2, sp[i], 0);
      run_pass(lat, b);
      checks++;
      if (res(2) !== ex[i]) begin
        failures++;
        $display("FAIL deriv_%0d got=%0d exp=%0d", i, res(2), ex[i]);
      end
    end
  endtask

  task automatic test_integral;
    int lat, b;
    int ex [4] = '{50, 100, 120, 120};
    cfg_pid(1, 0, 32'h8000, 0, 10000, -10000, 120, -120, 0, 0);
    set_io(1, 100, 0);
    for (int i = 0; i < 4; i++) begin
      run_pass(lat, b);
      checks++;
      if (res(1) !== ex[i]) begin
        failures++;
        $display("FAIL integral_%0d got=%0d exp=%0d", i, res(1), ex[i]);
      end
    end
  endtask

  task automatic test_antiwindup;
    int lat, b;
    int kp [4] = '{32'h20000, 0, 32'h20000, 0};
    int sp [4] = '{1000, 1, -1000, 1};
    int ex [4] = '{1500, 0, -1500, 0};
    cfg_pid(2, 0, 32'h8000, 0, 1500, -1500, 10000, -10000, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cfg(2, 0, kp[i]);
      set_io(2, sp[i], 0);
      run_pass(lat, b);
      checks++;
      if (res(2) !== ex[i]) begin
        failures++;
        $display("FAIL antiwindup_%0d got=%0d exp=%0d", i, res(2), ex[i]);
      end
    end
  endtask

  task automatic test_deadband;
    int lat, b;
    int sp [3] = '{20, 5, 11};
    int ex [3] = '{10, 0, 15};
    cfg_pid(3, 0, 32'h8000, 0, 10000, -10000, 10000, -10000, 10, 0);
    for (int i = 0; i < 3; i++) begin
      set_io(3, sp[i], 0);
      run_pass(lat, b);
      checks++;
      if (res(3) !== ex[i]) begin
        failures++;
        $display("FAIL deadband_%0d got=%0d exp=%0d", i, res(3), ex[i]);
      end
    end
  endtask

  task automatic test_overrun;
    int dones = 0;
    int dk = 0;
    set_io(0, 1000, 400);
    bus.update_controller = 1'b1;
    @(negedge clock);
    bus.update_controller = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (bus.done) begin
        dones++;
        if (dk == 0) dk = k;
      end
      if (k == 5) bus.update_controller = 1'b1;
      if (k == 6) begin
        bus.update_controller = 1'b0;
        checks++;
        if (bus.overrun !== 1'b1) begin
          failures++;
          $display("FAIL overrun_pulse got=%b exp=1", bus.overrun);
        end
      end
      if (k == 7) begin
        checks++;
        if (bus.overrun !== 1'b0) begin
          failures++;
          $display("FAIL overrun_width got=%b exp=0", bus.overrun);
        end
      end
      if (k == 8) begin
        bus.cfg_write   = 1'b1;
        bus.cfg_channel = 6'd0;
        bus.cfg_addr    = 4'd0;
        bus.cfg_data    = '0;
      end
      if (k == 9) begin
        bus.cfg_write = 1'b0;
        checks++;
        if (bus.cfg_error !== 1'b1) begin
          failures++;
          $display("FAIL cfg_busy_error got=%b exp=1", bus.cfg_error);
        end
      end
      @(negedge clock);
    end
    checks++;
    if (dones != 1 || dk != 25) begin
      failures++;
      $display("FAIL overrun_done count=%0d at=%0d exp 1 at 25", dones, dk);
    end
    checks++;
    if (res(0) !== 32'sd1200) begin
      failures++;
      $display("FAIL cfg_busy_kept got=%0d exp=1200", res(0));
    end
  endtask

  task automatic test_cfg_error;
    int addr [3] = '{9, 0, 7};
    int chan [3] = '{0, 4, 0};
    logic exp [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      cfg(chan[i], addr[i], 0);
      checks++;
      if (bus.cfg_error !== exp[i]) begin
        failures++;
        $display("FAIL cfg_error_%0d got=%b exp=%b", i, bus.cfg_error, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int dk [2] = '{0, 0};
    int dones = 0;
    bus.update_controller = 1'b1;
    @(negedge clock);
    for (int k = 1; k <= 60; k++) begin
      if (bus.done) begin
        if (dones < 2) dk[dones] = k;
        dones++;
      end
      if (k == 50) bus.update_controller = 1'b0;
      @(negedge clock);
    end
    checks++;
    if (dones != 2 || dk[0] != 25 || dk[1] != 50) begin
      failures++;
      $display("FAIL back_to_back count=%0d at=%0d,%0d exp 2 at 25,50",
               dones, dk[0], dk[1]);
    end
    checks++;
    if (bus.busy !== 1'b0 || res(0) !== 32'sd1200) begin
      failures++;
      $display("FAIL back_to_back_end busy=%b r0=%0d exp 0 1200",
               bus.busy, res(0));
    end
  endtask

  task automatic test_modes;
    int lat, b;
    cfg(0, 3, 1500);
    cfg(0, 8, 1);
    set_io(0, 20000, 400);
    run_pass(lat, b);
    checks++;
    if (res(0) !== 32'sd1500) begin
      failures++;
      $display("FAIL mode1_clamp got=%0d exp=1500", res(0));
    end
    cfg(1, 8, 2);
    run_pass(lat, b);
    checks++;
    if (res(1) !== 32'sd0) begin
      failures++;
      $display("FAIL mode2_zero got=%0d exp=0", res(1));
    end
    cfg(1, 8, 0);
    set_io(1, 100, 0);
    run_pass(lat, b);
    checks++;
    if (res(1) !== 32'sd50) begin
      failures++;
      $display("FAIL mode2_cleared got=%0d exp=50", res(1));
    end
  endtask

  task automatic test_reset_mid;
    int lat, b;
    int dones = 0;
    bus.update_controller = 1'b1;
    @(negedge clock);
    bus.update_controller = 1'b0;
    for (int k = 1; k < 10; k++) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || result !== '0) begin
      failures++;
      $display("FAIL reset_mid busy=%b result=%h exp 0 0", bus.busy, result);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) dones++;
      @(negedge clock);
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL reset_mid_done got=%0d exp=0", dones);
    end
    set_io(0, 1000, 400);
    run_pass(lat, b);
    checks++;
    if (res(0) !== 32'sd0 || lat != 25) begin
      failures++;
      $display("FAIL reset_mid_cfg r0=%0d lat=%0d exp 0 25", res(0), lat);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    state    = '0;
    setpoint = '0;
    bus.update_controller = 1'b0;
    bus.cfg_write   = 1'b0;
    bus.cfg_channel = '0;
    bus.cfg_addr    = '0;
    bus.cfg_data    = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    test_reset;
    test_basic;
    test_derivative;
    test_integral;
    test_antiwindup;
    test_deadband;
    test_overrun;
    test_cfg_error;
    test_back_to_back;
    test_modes;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
